// File: rtl/seq_pkg.sv
// seq_pkg -- shared definitions for prog_sequencer and its bench.
//   state_t         : sequencer FSM state encoding (also exported on StateDbg)
//   PROG_BASE       : start address of each of the four ROM programs
//   MEM_LAT_DEFAULT : default number of extra wait cycles per load
package seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        MWAIT = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int PROG_BASE [0:3] = '{0, 128, 256, 384};

    localparam int MEM_LAT_DEFAULT = 1;

endpackage

// File: rtl/sat_counter.sv
// sat_counter -- synchronous-clear, saturating up-counter.
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset (count -> 0)
//   clr   : synchronous clear, wins over inc
//   inc   : count up by one unless already all-ones
//   count : current value
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/prog_sequencer.sv
// prog_sequencer -- program-counter sequencer for a small microcoded datapath.
//
// Handshakes:
//   Req/Done is a four-phase handshake: the host raises Req, the sequencer
//   runs the selected program and raises Done; Done stays high until the host
//   drops Req, after which the sequencer returns to IDLE. InstrValid is a
//   one-cycle qualifier: the datapath commits the instruction at PC in every
//   cycle where InstrValid is high, and never otherwise.
//
// Ports:
//   Clk, Reset  : clock (rising edge), asynchronous active-high reset
//   Req, ProgSel: run request and program index (sampled in IDLE only)
//   InstrAck    : current instruction is the halt word
//   MemRdEn     : current instruction is a load
//   Branch/Taken/Target : branch decode, condition, destination
//   PC          : instruction ROM address
//   InstrValid  : commit strobe for the current instruction
//   Busy        : state is LOAD, RUN or MWAIT
//   Done        : program finished, held until Req drops
//   CycleCnt    : RUN + MWAIT cycles of the last/current run (saturating)
//   StateDbg    : current FSM state, for observation
module prog_sequencer
    import seq_pkg::*;
#(
    parameter int PC_W    = 10,
    parameter int CNT_W   = 16,
    parameter int MEM_LAT = MEM_LAT_DEFAULT
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Req,
    input  logic [1:0]       ProgSel,
    input  logic             InstrAck,
    input  logic             MemRdEn,
    input  logic             Branch,
    input  logic             Taken,
    input  logic [PC_W-1:0]  Target,
    output logic [PC_W-1:0]  PC,
    output logic             InstrValid,
    output logic             Busy,
    output logic             Done,
    output logic [CNT_W-1:0] CycleCnt,
    output state_t           StateDbg
);

    localparam logic [2:0] LAT = 3'(MEM_LAT);

    state_t          state, state_nxt;
    logic [PC_W-1:0] pc_nxt;
    logic [2:0]      wait_cnt, wait_nxt;
    logic [1:0]      sel_q, sel_nxt;
    logic            cnt_clr, cnt_inc;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            PC       <= '0;
            wait_cnt <= '0;
            sel_q    <= '0;
        end else begin
            state    <= state_nxt;
            PC       <= pc_nxt;
            wait_cnt <= wait_nxt;
            sel_q    <= sel_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        pc_nxt     = PC;
        wait_nxt   = wait_cnt;
        sel_nxt    = sel_q;
        InstrValid = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        case (state)
            IDLE: begin
                if (Req) begin
                    sel_nxt   = ProgSel;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                // Base addresses wider than PC_W simply wrap into the PC range.
                pc_nxt    = PC_W'(PROG_BASE[sel_q]);
                cnt_clr   = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                cnt_inc = 1'b1;
                if (InstrAck) begin
                    InstrValid = 1'b1;
                    state_nxt  = DONE;
                end else if (MemRdEn && (LAT != 3'd0)) begin
                    // Load stalls: PC held, commit deferred to last MWAIT cycle.
                    wait_nxt  = LAT;
                    state_nxt = MWAIT;
                end else if (Branch && Taken) begin
                    InstrValid = 1'b1;
                    pc_nxt     = Target;
                end else begin
                    InstrValid = 1'b1;
                    pc_nxt     = PC + PC_W'(1);
                end
            end
            MWAIT: begin
                cnt_inc = 1'b1;
                if (wait_cnt <= 3'd1) begin
                    InstrValid = 1'b1;
                    pc_nxt     = PC + PC_W'(1);
                    wait_nxt   = 3'd0;
                    state_nxt  = RUN;
                end else begin
                    wait_nxt = wait_cnt - 3'd1;
                end
            end
            DONE: begin
                if (!Req) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    sat_counter #(
        .W(CNT_W)
    ) u_cycle_cnt (
        .clk  (Clk),
        .rst  (Reset),
        .clr  (cnt_clr),
        .inc  (cnt_inc),
        .count(CycleCnt)
    );

    assign Busy     = (state == LOAD) || (state == RUN) || (state == MWAIT);
    assign Done     = (state == DONE);
    assign StateDbg = state;

endmodule

// File: tb/tb_prog_sequencer.sv
// tb_prog_sequencer -- directed bench for prog_sequencer.
// Two instances: dut_a with default parameters, dut_b with PC_W=4, CNT_W=3,
// MEM_LAT=2. Drivers push expected commit PCs and final cycle counts into
// queues; a negedge monitor pops them whenever InstrValid is high or Done rises.
module tb_prog_sequencer;
    import seq_pkg::*;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic a_rst, b_rst;

    // dut_a signals
    logic        a_req, a_ack, a_mrd, a_br, a_tk;
    logic [1:0]  a_sel;
    logic [9:0]  a_tgt, a_pc;
    logic        a_valid, a_busy, a_done;
    logic [15:0] a_cnt;
    state_t      a_st;

    // dut_b signals
    logic        b_req, b_ack, b_mrd, b_br, b_tk;
    logic [1:0]  b_sel;
    logic [3:0]  b_tgt, b_pc;
    logic        b_valid, b_busy, b_done;
    logic [2:0]  b_cnt;
    state_t      b_st;

    prog_sequencer dut_a (
        .Clk(clk), .Reset(a_rst), .Req(a_req), .ProgSel(a_sel),
        .InstrAck(a_ack), .MemRdEn(a_mrd), .Branch(a_br), .Taken(a_tk),
        .Target(a_tgt), .PC(a_pc), .InstrValid(a_valid), .Busy(a_busy),
        .Done(a_done), .CycleCnt(a_cnt), .StateDbg(a_st)
    );

    prog_sequencer #(.PC_W(4), .CNT_W(3), .MEM_LAT(2)) dut_b (
        .Clk(clk), .Reset(b_rst), .Req(b_req), .ProgSel(b_sel),
        .InstrAck(b_ack), .MemRdEn(b_mrd), .Branch(b_br), .Taken(b_tk),
        .Target(b_tgt), .PC(b_pc), .InstrValid(b_valid), .Busy(b_busy),
        .Done(b_done), .CycleCnt(b_cnt), .StateDbg(b_st)
    );

    // scoreboard
    int checks = 0;
    int passes = 0;
    logic [9:0]  a_pc_q[$];
    logic [15:0] a_cnt_q[$];
    logic [3:0]  b_pc_q[$];
    logic [2:0]  b_cnt_q[$];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic miss(input string name, input longint act);
        checks++;
        $display("FAIL %s: got %0d expected nothing (queue empty)", name, act);
    endtask

    logic a_done_d = 1'b0;
    logic b_done_d = 1'b0;
    always @(negedge clk) begin
        if (a_valid) begin
            if (a_pc_q.size() == 0) miss("a_commit_pc", a_pc);
            else check("a_commit_pc", a_pc, a_pc_q.pop_front());
        end
        if (a_done && !a_done_d) begin
            if (a_cnt_q.size() == 0) miss("a_cyclecnt", a_cnt);
            else check("a_cyclecnt", a_cnt, a_cnt_q.pop_front());
        end
        a_done_d = a_done;
        if (b_valid) begin
            if (b_pc_q.size() == 0) miss("b_commit_pc", b_pc);
            else check("b_commit_pc", b_pc, b_pc_q.pop_front());
        end
        if (b_done && !b_done_d) begin
            if (b_cnt_q.size() == 0) miss("b_cyclecnt", b_cnt);
            else check("b_cyclecnt", b_cnt, b_cnt_q.pop_front());
        end
        b_done_d = b_done;
    end

    // drivers: inputs change 1 time unit after the rising edge
    task automatic a_set(input logic ack, mrd, br, tk, input logic [9:0] tgt);
        a_ack = ack; a_mrd = mrd; a_br = br; a_tk = tk; a_tgt = tgt;
    endtask

    task automatic a_cyc(input logic ack, mrd, br, tk, input logic [9:0] tgt);
        a_set(ack, mrd, br, tk, tgt);
        @(posedge clk); #1;
    endtask

    task automatic b_set(input logic ack, mrd, br, tk, input logic [3:0] tgt);
        b_ack = ack; b_mrd = mrd; b_br = br; b_tk = tk; b_tgt = tgt;
    endtask

    task automatic b_cyc(input logic ack, mrd, br, tk, input logic [3:0] tgt);
        b_set(ack, mrd, br, tk, tgt);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        a_rst = 1'b1; b_rst = 1'b1;
        a_req = 1'b0; a_sel = 2'd0; a_set(0, 0, 0, 0, 10'd0);
        b_req = 1'b0; b_sel = 2'd0; b_set(0, 0, 0, 0, 4'd0);
        #2;
        check("rst_a_pc", a_pc, 0);
        check("rst_a_cnt", a_cnt, 0);
        check("rst_a_busy", a_busy, 0);
        check("rst_a_done", a_done, 0);
        check("rst_a_valid", a_valid, 0);
        check("rst_a_state", a_st, IDLE);
        check("rst_b_pc", b_pc, 0);
        @(posedge clk); #1;
        a_rst = 1'b0; b_rst = 1'b0;

        // run 1: program 1 at 128, three ALU ops then halt
        a_req = 1'b1; a_sel = 2'd1;
        a_pc_q.push_back(10'd128); a_pc_q.push_back(10'd129);
        a_pc_q.push_back(10'd130); a_pc_q.push_back(10'd131);
        a_cnt_q.push_back(16'd4);
        a_cyc(0, 0, 0, 0, 10'd0);                 // edge 1: IDLE -> LOAD
        check("a_load_state", a_st, LOAD);
        check("a_load_busy", a_busy, 1);
        check("a_load_valid", a_valid, 0);
        a_sel = 2'd2;                             // must be ignored
        a_cyc(0, 0, 0, 0, 10'd0);                 // edge 2: LOAD -> RUN
        check("a_base_pc", a_pc, 128);
        for (int i = 0; i < 3; i++) a_cyc(0, 0, 0, 0, 10'd0);
        a_cyc(1, 0, 0, 0, 10'd0);                 // edge 6: halt -> DONE
        check("a_done_edge6", a_done, 1);
        check("a_done_state", a_st, DONE);
        for (int i = 0; i < 3; i++) begin
            a_cyc(0, 0, 0, 0, 10'd0);
            check("a_done_held", a_done, 1);
        end
        check("a_done_pc_held", a_pc, 131);
        a_req = 1'b0;
        a_cyc(0, 0, 0, 0, 10'd0);
        check("a_idle_state", a_st, IDLE);
        check("a_idle_done", a_done, 0);
        check("a_idle_pc_held", a_pc, 131);
        check("a_idle_cnt_held", a_cnt, 4);

        // run 2: program 0, branches, a MEM_LAT=1 load, halt with all decodes set
        a_req = 1'b1; a_sel = 2'd0;
        for (int i = 0; i <= 10; i++) a_pc_q.push_back(10'(i));
        a_pc_q.push_back(10'd40); a_pc_q.push_back(10'd41); a_pc_q.push_back(10'd42);
        a_cnt_q.push_back(16'd15);
        a_cyc(0, 0, 0, 0, 10'd0);
        a_cyc(0, 0, 0, 0, 10'd0);
        for (int i = 0; i < 10; i++) a_cyc(0, 0, 0, 0, 10'd0);
        check("a_pc_before_branch", a_pc, 10);
        a_cyc(0, 0, 1, 1, 10'd40);
        check("a_branch_taken", a_pc, 40);
        a_cyc(0, 0, 1, 0, 10'd99);
        check("a_branch_not_taken", a_pc, 41);
        a_set(0, 1, 0, 0, 10'd0);
        #1;
        check("a_load_run_valid", a_valid, 0);
        @(posedge clk); #1;
        check("a_mwait_state", a_st, MWAIT);
        check("a_mwait_pc", a_pc, 41);
        check("a_mwait_last_valid", a_valid, 1);
        a_cyc(0, 0, 0, 0, 10'd0);
        check("a_after_load_pc", a_pc, 42);
        a_cyc(1, 1, 1, 1, 10'd7);
        check("a_halt_prio_state", a_st, DONE);
        check("a_halt_prio_pc", a_pc, 42);
        a_req = 1'b0;
        a_cyc(0, 0, 0, 0, 10'd0);
        check("a_idle2_state", a_st, IDLE);

        // dut_b: load with MEM_LAT=2, PC wrap, counter saturation
        b_req = 1'b1; b_sel = 2'd2;
        for (int i = 0; i < 16; i++) b_pc_q.push_back(4'(i));
        b_pc_q.push_back(4'd0); b_pc_q.push_back(4'd1);
        b_cnt_q.push_back(3'd7);
        b_cyc(0, 0, 0, 0, 4'd0);
        b_cyc(0, 0, 0, 0, 4'd0);
        check("b_base_pc", b_pc, 0);
        for (int i = 0; i < 5; i++) b_cyc(0, 0, 0, 0, 4'd0);
        b_set(0, 1, 0, 0, 4'd0);
        #1;
        check("b_load_c1_valid", b_valid, 0);
        @(posedge clk); #1;
        check("b_load_c2_valid", b_valid, 0);
        check("b_load_c2_pc", b_pc, 5);
        @(posedge clk); #1;
        check("b_load_c3_valid", b_valid, 1);
        check("b_load_c3_pc", b_pc, 5);
        b_cyc(0, 0, 0, 0, 4'd0);
        check("b_after_load_pc", b_pc, 6);
        for (int i = 6; i < 16; i++) b_cyc(0, 0, 0, 0, 4'd0);
        check("b_pc_wrap", b_pc, 0);
        b_cyc(0, 0, 0, 0, 4'd0);
        b_cyc(1, 0, 0, 0, 4'd0);
        check("b_cnt_saturated", b_cnt, 7);
        b_req = 1'b0;
        b_cyc(0, 0, 0, 0, 4'd0);

        // dut_b: reset pulse in the middle of MWAIT, Req held high throughout
        b_req = 1'b1; b_sel = 2'd3;
        b_pc_q.push_back(4'd0); b_pc_q.push_back(4'd1); b_pc_q.push_back(4'd2);
        b_cyc(0, 0, 0, 0, 4'd0);
        b_cyc(0, 0, 0, 0, 4'd0);
        for (int i = 0; i < 3; i++) b_cyc(0, 0, 0, 0, 4'd0);
        b_cyc(0, 1, 0, 0, 4'd0);
        check("b_pre_rst_state", b_st, MWAIT);
        #2 b_rst = 1'b1;
        #1;
        check("b_async_state", b_st, IDLE);
        check("b_async_pc", b_pc, 0);
        check("b_async_cnt", b_cnt, 0);
        check("b_async_busy", b_busy, 0);
        check("b_async_done", b_done, 0);
        check("b_async_valid", b_valid, 0);
        b_set(0, 0, 0, 0, 4'd0);
        #2 b_rst = 1'b0;
        b_pc_q.push_back(4'd0);
        b_cnt_q.push_back(3'd1);
        @(posedge clk); #1;
        check("b_restart_state", b_st, LOAD);
        check("b_restart_busy", b_busy, 1);
        b_cyc(0, 0, 0, 0, 4'd0);
        check("b_restart_pc", b_pc, 0);
        b_cyc(1, 0, 0, 0, 4'd0);
        check("b_restart_done", b_done, 1);
        b_req = 1'b0;
        b_cyc(0, 0, 0, 0, 4'd0);
        check("b_restart_idle", b_st, IDLE);

        repeat (2) @(posedge clk);
        #1;
        check("a_pc_q_drained", a_pc_q.size(), 0);
        check("a_cnt_q_drained", a_cnt_q.size(), 0);
        check("b_pc_q_drained", b_pc_q.size(), 0);
        check("b_cnt_q_drained", b_cnt_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/prog_sequencer.md
PROG_SEQUENCER -- requirements
Module: prog_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 10, meaning program-counter width.
REQ-002 SHALL have parameter CNT_W, default 16, meaning cycle-counter width.
REQ-003 SHALL have parameter MEM_LAT, default 1, range 0..7, meaning extra wait cycles per load.
REQ-004 SHALL have port Clk  in  1  meaning sole clock, rising edge.
REQ-005 SHALL have port Reset  in  1  meaning asynchronous, active-high reset.
REQ-006 SHALL have port Req  in  1  meaning run request, level, four-phase handshake with Done.
REQ-007 SHALL have port ProgSel  in  2  meaning program index, sampled in IDLE.
REQ-008 SHALL have port InstrAck  in  1  meaning current instruction is the all-ones halt word.
REQ-009 SHALL have port MemRdEn  in  1  meaning current instruction is a load.
REQ-010 SHALL have port Branch  in  1  meaning current instruction is branch-mode (bit 8 set).
REQ-011 SHALL have port Taken  in  1  meaning branch condition flag from ALU.
REQ-012 SHALL have port Target  in  PC_W  meaning branch destination.
REQ-013 SHALL have port PC  out  PC_W  meaning instruction ROM address.
REQ-014 SHALL have port InstrValid  out  1  meaning datapath may commit the current instruction this cycle.
REQ-015 SHALL have port Busy  out  1  meaning state is LOAD, RUN or MWAIT.
REQ-016 SHALL have port Done  out  1  meaning program finished, held until Req drops.
REQ-017 SHALL have port CycleCnt  out  CNT_W  meaning cycles spent in RUN plus MWAIT for the last or current run.

Function
REQ-018 SHALL implement FSM states IDLE, LOAD, RUN, MWAIT, DONE, all registered.
REQ-019 SHALL, in IDLE with Req=1, latch ProgSel and go to LOAD next cycle; with Req=0, stay in IDLE.
REQ-020 SHALL, in LOAD (exactly 1 cycle), set PC to PROG_BASE[latched ProgSel], clear CycleCnt and go to RUN.
REQ-021 SHALL, in RUN, decode with priority InstrAck > MemRdEn > (Branch and Taken) > sequential.
REQ-022 SHALL, on InstrAck in RUN, assert InstrValid, hold PC and go to DONE.
REQ-023 SHALL, on MemRdEn in RUN with MEM_LAT>0, drive InstrValid=0, hold PC, load the wait count with MEM_LAT and go to MWAIT.
REQ-024 SHALL, on MemRdEn in RUN with MEM_LAT=0, treat the load as sequential.
REQ-025 SHALL, in MWAIT, decrement the wait count each cycle; at count 1, assert InstrValid, set PC to PC+1 and return to RUN.
REQ-026 SHALL, on Branch and Taken in RUN, assert InstrValid and set PC to Target next cycle; on Branch without Taken, set PC to PC+1.
REQ-027 SHALL, for sequential instructions in RUN, assert InstrValid and set PC to PC+1 modulo 2^PC_W, so all-ones wraps to 0.
REQ-028 SHALL increment CycleCnt every RUN and MWAIT cycle, saturating at all-ones with no wrap.
REQ-029 SHALL, in DONE, drive Done=1; it SHALL return to IDLE only when Req=0 and SHALL ignore a held Req=1.
REQ-030 SHALL hold PC and CycleCnt in IDLE and DONE so the testbench can read them.
REQ-031 SHALL drive InstrValid=0 in IDLE, LOAD, DONE, and in MWAIT except at its final cycle.
REQ-032 SHALL ignore ProgSel changes outside IDLE.

Reset
REQ-033 SHALL, on Reset=1 at any time including mid-run, immediately force state IDLE, PC=0, CycleCnt=0, wait count=0, Done=0, Busy=0 and InstrValid=0.
REQ-034 SHALL, after Reset deasserts with Req already high, start a run on the first rising edge.

Structure
REQ-035 SHALL take the state enum, PROG_BASE[0:3] (defaults 0, 128, 256, 384) and MEM_LAT default from shared package seq_pkg.
REQ-036 SHALL place the saturating cycle counter in one sub-module, sat_counter.

Verification
REQ-037 SHALL cover: ProgSel=1, Req=1, ROM at 128 = 3 ALU ops then halt -> PC 128,129,130,131; Done at cycle 6 after Req; CycleCnt=4.
REQ-038 SHALL cover: MEM_LAT=2, a load at PC 5 -> PC holds 5 for 3 cycles, InstrValid only in the 3rd, then PC=6.
REQ-039 SHALL cover: Branch=1, Taken=1, Target=40 at PC 10 -> PC=40 next cycle; the same with Taken=0 -> PC=11.
REQ-040 SHALL cover: InstrAck=1 together with MemRdEn=1 and Branch=1 -> DONE next cycle, PC unchanged; Req held high keeps Done=1; Req=0 -> IDLE.
REQ-041 SHALL cover: PC_W=4 running straight from 15 -> PC=0; CNT_W=3 over 10 cycles -> CycleCnt saturates at 7.
REQ-042 SHALL cover: Reset pulse mid-MWAIT -> all outputs zero asynchronously before the next edge; a new Req then runs normally.
